// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: load-type codes and register-file
// write-source encodings.
package wb_pkg;

   typedef enum logic [2:0] {
      LD_W  = 3'd0,
      LD_B  = 3'd1,
      LD_BU = 3'd2,
      LD_H  = 3'd3,
      LD_HU = 3'd4
   } ld_type_e;

   localparam logic RF_SRC_PIPE = 1'b0;
   localparam logic RF_SRC_LATE = 1'b1;

endpackage

// File: rtl/wb_stage_arb_late_fifo.sv
// Late-result FIFO for the writeback stage. Each entry carries a live bit that a
// younger pipe write to the same register can clear (WAW kill).
module wb_late_fifo
   import wb_pkg::*;
#(
   parameter int DW         = 32,
   parameter int AW         = 5,
   parameter int LATE_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [AW-1:0]        push_addr,
   input  logic [DW-1:0]        push_data,
   input  logic                 pop,
   input  logic                 kill,
   input  logic [AW-1:0]        kill_addr,
   output logic [AW-1:0]        head_addr,
   output logic [DW-1:0]        head_data,
   output logic                 head_live,
   output logic                 full,
   output logic                 empty,
   output logic [(1<<AW)-1:0]   pend_mask
);

   localparam int PW = (LATE_DEPTH > 1) ? $clog2(LATE_DEPTH) : 1;
   localparam int CW = $clog2(LATE_DEPTH + 1);

   logic [AW-1:0]         addr_q [LATE_DEPTH];
   logic [DW-1:0]         data_q [LATE_DEPTH];
   logic [LATE_DEPTH-1:0] live_q;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(LATE_DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   assign full    = (count == CW'(LATE_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         live_q <= '0;
      end else begin
         for (int i = 0; i < LATE_DEPTH; i++) begin
            if (kill && live_q[i] && (addr_q[i] == kill_addr)) live_q[i] <= 1'b0;
         end
         if (do_pop) begin
            live_q[rd_ptr] <= 1'b0;
            rd_ptr         <= ptr_inc(rd_ptr);
         end
         // An entry pushed alongside a pipe write to the same register is older, so it arrives dead.
         if (do_push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
            live_q[wr_ptr] <= (push_addr != '0) && !(kill && (kill_addr == push_addr));
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign head_live = live_q[rd_ptr];

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < LATE_DEPTH; i++) begin
         if (live_q[i]) pend_mask[addr_q[i]] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

endmodule

// File: rtl/wb_stage_arb.sv
// Writeback stage: MEM/WB register, load extension, result select, and the
// register-file write port shared between the pipe and the late-result FIFO.
module wb_stage_arb
   import wb_pkg::*;
#(
   parameter int DW         = 32,
   parameter int AW         = 5,
   parameter int LATE_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m_valid,
   input  logic                 m_regwrite,
   input  logic                 m_memtoreg,
   input  logic                 m_pctoreg,
   input  logic [2:0]           m_ldtype,
   input  logic [AW-1:0]        m_writereg,
   input  logic [DW-1:0]        m_aluout,
   input  logic [DW-1:0]        m_readdata,
   input  logic [DW-1:0]        m_pc,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 late_valid,
   output logic                 late_ready,
   input  logic [AW-1:0]        late_addr,
   input  logic [DW-1:0]        late_data,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_waddr,
   output logic [DW-1:0]        rf_wdata,
   output logic                 rf_src,
   output logic [(1<<AW)-1:0]   pend_mask
);

   localparam int BW = $clog2(DW / 8);

   logic          wb_valid;
   logic          wb_regwrite;
   logic          wb_memtoreg;
   logic          wb_pctoreg;
   logic          wb_done;
   logic [2:0]    wb_ldtype;
   logic [AW-1:0] wb_writereg;
   logic [DW-1:0] wb_aluout;
   logic [DW-1:0] wb_readdata;
   logic [DW-1:0] wb_pc;

   logic          pipe_req;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [DW-1:0] load_ext;
   logic [DW-1:0] result;

   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          head_live;
   logic          fifo_full;
   logic          fifo_empty;

   assign pipe_req = wb_valid && wb_regwrite && (wb_writereg != '0) && !wb_done;

   // A stalled instruction writes once; done suppresses the repeat while it is held.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_memtoreg <= 1'b0;
         wb_pctoreg  <= 1'b0;
         wb_done     <= 1'b0;
         wb_ldtype   <= '0;
         wb_writereg <= '0;
         wb_aluout   <= '0;
         wb_readdata <= '0;
         wb_pc       <= '0;
      end else if (flush) begin
         wb_valid <= 1'b0;
         wb_done  <= 1'b0;
      end else if (stall) begin
         if (pipe_req) wb_done <= 1'b1;
      end else begin
         wb_valid    <= m_valid;
         wb_regwrite <= m_regwrite;
         wb_memtoreg <= m_memtoreg;
         wb_pctoreg  <= m_pctoreg;
         wb_ldtype   <= m_ldtype;
         wb_writereg <= m_writereg;
         wb_aluout   <= m_aluout;
         wb_readdata <= m_readdata;
         wb_pc       <= m_pc;
         wb_done     <= 1'b0;
      end
   end

   // Little-endian lanes; the halfword lane ignores address bit 0.
   assign lane_b = 8'(wb_readdata >> {wb_aluout[BW-1:0], 3'b000});
   assign lane_h = 16'(wb_readdata >> {wb_aluout[BW-1:1], 4'b0000});

   always_comb begin
      load_ext = wb_readdata;
      case (wb_ldtype)
         LD_B:    load_ext = {{(DW-8){lane_b[7]}}, lane_b};
         LD_BU:   load_ext = {{(DW-8){1'b0}}, lane_b};
         LD_H:    load_ext = {{(DW-16){lane_h[15]}}, lane_h};
         LD_HU:   load_ext = {{(DW-16){1'b0}}, lane_h};
         default: load_ext = wb_readdata;
      endcase
   end

   always_comb begin
      result = wb_aluout;
      if (wb_pctoreg)       result = wb_pc + DW'(8);
      else if (wb_memtoreg) result = load_ext;
   end

   wb_late_fifo #(
      .DW         (DW),
      .AW         (AW),
      .LATE_DEPTH (LATE_DEPTH)
   ) u_late_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (late_valid),
      .push_addr  (late_addr),
      .push_data  (late_data),
      .pop        (!pipe_req),
      .kill       (pipe_req),
      .kill_addr  (wb_writereg),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .head_live  (head_live),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .pend_mask  (pend_mask)
   );

   assign late_ready = !fifo_full;

   // Pipe always wins; a dead FIFO head is drained silently.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      rf_src   = RF_SRC_PIPE;
      if (pipe_req) begin
         rf_we    = 1'b1;
         rf_waddr = wb_writereg;
         rf_wdata = result;
      end else if (!fifo_empty && head_live) begin
         rf_we    = 1'b1;
         rf_waddr = head_addr;
         rf_wdata = head_data;
         rf_src   = RF_SRC_LATE;
      end
   end

endmodule
